// File: rtl/dot11_rx_cfg_ctrl_pkg.sv
// Shared definitions for the dot11 receive configuration controller:
// controller state encodings, dot11 datapath state codes, setting-bus
// register addresses and table-entry helpers.
package dot11_rx_cfg_ctrl_pkg;

  // Existing dot11 receive datapath state codes (observed on debug taps).
  localparam logic [3:0] DOT11_ST_IDLE    = 4'd0;
  localparam logic [3:0] DOT11_ST_SEARCH  = 4'd1;
  localparam logic [3:0] DOT11_ST_SYNC    = 4'd2;
  localparam logic [3:0] DOT11_ST_PAYLOAD = 4'd3;

  // Configuration controller states.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_HOLD_RST = 4'd1,
    S_FETCH    = 4'd2,
    S_ISSUE    = 4'd3,
    S_GAP      = 4'd4,
    S_RUN      = 4'd5
  } cfg_state_e;

  // Setting-bus register addresses of the dot11 receive datapath.
  localparam logic [7:0] SR_SKIP_SAMPLE  = 8'h05;
  localparam logic [7:0] SR_PKT_THRESH   = 8'h06;
  localparam logic [7:0] SR_CFO_TRACK    = 8'h07;
  localparam logic [7:0] SR_FREQ_OFFSET  = 8'h08;
  localparam logic [7:0] SR_POWER_THRESH = 8'h09;

  // Table address that terminates the bring-up table early.
  localparam logic [7:0] END_ADDR_DEFAULT = 8'hFF;

  localparam int unsigned EntryW = 40;

  function automatic logic [7:0] entry_addr(logic [EntryW-1:0] entry);
    return entry[39:32];
  endfunction

  function automatic logic [31:0] entry_data(logic [EntryW-1:0] entry);
    return entry[31:0];
  endfunction

endpackage

// File: rtl/dot11_rx_cfg_ctrl_if.sv
// Host write request channel plus the setting bus towards dot11.
// The controller side is the master: it drives the setting bus and host_ack.
interface dot11_rx_cfg_ctrl_if;

  logic        host_req;
  logic [7:0]  host_addr;
  logic [31:0] host_data;
  logic        host_ack;

  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;

  modport master (
    input  host_req,
    input  host_addr,
    input  host_data,
    output host_ack,
    output set_stb,
    output set_addr,
    output set_data
  );

  modport slave (
    output host_req,
    output host_addr,
    output host_data,
    input  host_ack,
    input  set_stb,
    input  set_addr,
    input  set_data
  );

endinterface

// File: rtl/dot11_rx_cfg_ctrl_cfg_gap_timer.sv
// Idle-gap timer enforced after every setting-bus strobe. Loading a value of
// N keeps the timer active for N cycles; expire flags the last of them.
module dot11_rx_cfg_ctrl_cfg_gap_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       active,
  output logic       expire
);

  logic [3:0] gap_cnt_q;

  // Down-counter; load has priority over counting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gap_cnt_q <= 4'd0;
    end else if (load) begin
      gap_cnt_q <= load_val;
    end else if (gap_cnt_q != 4'd0) begin
      gap_cnt_q <= gap_cnt_q - 4'd1;
    end
  end

  assign active = (gap_cnt_q != 4'd0);
  assign expire = (gap_cnt_q == 4'd1);

endmodule

// File: rtl/dot11_rx_cfg_ctrl.sv
// Bring-up and configuration sequencer for the dot11 receive datapath.
// Holds dot11 in reset, replays the settings table over the setting bus,
// releases reset/asserts enable, then forwards host register writes.
module dot11_rx_cfg_ctrl
  import dot11_rx_cfg_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned GAP         = 2,
  parameter logic [7:0]  END_ADDR    = END_ADDR_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic [7:0]           tbl_idx,
  input  logic [EntryW-1:0]    tbl_entry,
  dot11_rx_cfg_ctrl_if.master  bus,
  output logic                 dot11_reset,
  output logic                 dot11_enable,
  output logic                 busy,
  output logic                 done
);

  localparam logic [7:0]  LastIdx = 8'(NUM_ENTRIES - 1);
  localparam logic [15:0] RstLast = 16'(RST_CYCLES - 1);
  localparam logic [3:0]  GapVal  = 4'(GAP);
  localparam bit          HasGap  = (GAP != 0);

  cfg_state_e  state_q;
  cfg_state_e  ret_q;
  logic [15:0] rst_cnt_q;
  logic [7:0]  tbl_idx_q;
  logic        set_stb_q;
  logic [7:0]  set_addr_q;
  logic [31:0] set_data_q;
  logic        host_ack_q;
  logic        dot11_reset_q;
  logic        dot11_enable_q;
  logic        busy_q;
  logic        done_q;

  logic entry_end;
  logic is_last;
  logic issue_go;
  logic host_go;
  logic gap_load;
  logic gap_active;
  logic gap_expire;

  // Decode of the current table entry and the host arbitration decision.
  always_comb begin
    entry_end = (entry_addr(tbl_entry) == END_ADDR);
    is_last   = (tbl_idx_q == LastIdx);
    issue_go  = (state_q == S_ISSUE) && !entry_end;
    // A restart request takes priority over a coincident host write.
    host_go   = (state_q == S_RUN) && !start && bus.host_req && !gap_active;
    gap_load  = HasGap && (issue_go || host_go);
  end

  dot11_rx_cfg_ctrl_cfg_gap_timer u_gap_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (gap_load),
    .load_val (GapVal),
    .active   (gap_active),
    .expire   (gap_expire)
  );

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      ret_q          <= S_IDLE;
      rst_cnt_q      <= 16'd0;
      tbl_idx_q      <= 8'd0;
      set_stb_q      <= 1'b0;
      set_addr_q     <= 8'd0;
      set_data_q     <= 32'd0;
      host_ack_q     <= 1'b0;
      dot11_reset_q  <= 1'b1;
      dot11_enable_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      set_stb_q  <= 1'b0;
      host_ack_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_HOLD_RST;
            rst_cnt_q <= 16'd0;
            tbl_idx_q <= 8'd0;
            busy_q    <= 1'b1;
          end
        end
        S_HOLD_RST: begin
          if (rst_cnt_q == RstLast) begin
            state_q <= S_FETCH;
          end else begin
            rst_cnt_q <= rst_cnt_q + 16'd1;
          end
        end
        // tbl_idx is stable here, so the ROM output is valid next cycle.
        S_FETCH: begin
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (entry_end) begin
            state_q        <= S_RUN;
            dot11_reset_q  <= 1'b0;
            dot11_enable_q <= 1'b1;
            done_q         <= 1'b1;
            busy_q         <= 1'b0;
          end else begin
            set_stb_q  <= 1'b1;
            set_addr_q <= entry_addr(tbl_entry);
            set_data_q <= entry_data(tbl_entry);
            // The index saturates on the last entry; there is no wrap.
            if (!is_last) begin
              tbl_idx_q <= tbl_idx_q + 8'd1;
            end
            ret_q <= is_last ? S_RUN : S_FETCH;
            if (HasGap) begin
              state_q <= S_GAP;
            end else if (is_last) begin
              state_q        <= S_RUN;
              dot11_reset_q  <= 1'b0;
              dot11_enable_q <= 1'b1;
              done_q         <= 1'b1;
              busy_q         <= 1'b0;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_GAP: begin
          if (gap_expire) begin
            if (ret_q == S_RUN) begin
              state_q <= S_RUN;
              busy_q  <= 1'b0;
              // Only the first arrival in S_RUN completes bring-up.
              if (!dot11_enable_q) begin
                dot11_reset_q  <= 1'b0;
                dot11_enable_q <= 1'b1;
                done_q         <= 1'b1;
              end
            end else begin
              state_q <= ret_q;
            end
          end
        end
        S_RUN: begin
          if (start) begin
            state_q        <= S_HOLD_RST;
            rst_cnt_q      <= 16'd0;
            tbl_idx_q      <= 8'd0;
            dot11_reset_q  <= 1'b1;
            dot11_enable_q <= 1'b0;
            busy_q         <= 1'b1;
          end else if (host_go) begin
            set_stb_q  <= 1'b1;
            host_ack_q <= 1'b1;
            set_addr_q <= bus.host_addr;
            set_data_q <= bus.host_data;
            if (HasGap) begin
              state_q <= S_GAP;
              ret_q   <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tbl_idx      = tbl_idx_q;
  assign bus.set_stb  = set_stb_q;
  assign bus.set_addr = set_addr_q;
  assign bus.set_data = set_data_q;
  assign bus.host_ack = host_ack_q;
  assign dot11_reset  = dot11_reset_q;
  assign dot11_enable = dot11_enable_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_dot11_rx_cfg_ctrl.sv
// Bench for dot11_rx_cfg_ctrl: a timing model of bring-up and host writes
// predicts every setting-bus strobe and done pulse into queues; a monitor
// compares whatever the DUT presents against the queue heads.
module tb_dot11_rx_cfg_ctrl;
  import dot11_rx_cfg_ctrl_pkg::*;

  localparam int N   = 8;
  localparam int RST = 4;
  localparam int GAP = 2;
  localparam logic [7:0] END = END_ADDR_DEFAULT;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
    bit          host;
  } stb_t;

  logic        clock;
  logic        rst_n;
  logic        start;
  logic [7:0]  tbl_idx;
  logic [39:0] tbl_entry;
  logic        dot11_reset;
  logic        dot11_enable;
  logic        busy;
  logic        done;

  logic [39:0] rom [N];

  dot11_rx_cfg_ctrl_if bus ();

  dot11_rx_cfg_ctrl #(
    .NUM_ENTRIES (N),
    .RST_CYCLES  (RST),
    .GAP         (GAP),
    .END_ADDR    (END)
  ) dut (
    .clock        (clock),
    .reset        (rst_n),
    .start        (start),
    .tbl_idx      (tbl_idx),
    .tbl_entry    (tbl_entry),
    .bus          (bus),
    .dot11_reset  (dot11_reset),
    .dot11_enable (dot11_enable),
    .busy         (busy),
    .done         (done)
  );

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  stb_t exp_stb[$];
  int   exp_done[$];
  int   host_avail = 0;
  int   exp_ack = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous settings ROM.
  always @(posedge clock) tbl_entry <= rom[tbl_idx[2:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_stb(input int c, input logic [7:0] a, input logic [31:0] d, input bit h);
    stb_t e;
    int   pos;
    e.cyc = c;
    e.addr = a;
    e.data = d;
    e.host = h;
    pos = exp_stb.size();
    for (int i = 0; i < exp_stb.size(); i++) begin
      if (exp_stb[i].cyc > c) begin
        pos = i;
        break;
      end
    end
    exp_stb.insert(pos, e);
  endtask

  // Bring-up timing from the start edge s: first strobe RST+2 after start,
  // strobes GAP+2 apart, done on the END entry's issue slot or GAP after the
  // final entry's strobe.
  task automatic model_bringup(input int s, output int done_c, output int last_idx);
    int t;
    t = s + RST + 2;
    done_c = t;
    last_idx = 0;
    for (int i = 0; i < N; i++) begin
      if (rom[i][39:32] == END) begin
        done_c = t;
        last_idx = i;
        break;
      end
      push_stb(t, rom[i][39:32], rom[i][31:0], 1'b0);
      if (i == N - 1) begin
        done_c = t + GAP;
        last_idx = i;
        break;
      end
      t = t + GAP + 2;
    end
    exp_done.push_back(done_c);
    host_avail = done_c + 1;
  endtask

  task automatic host_issue(input logic [7:0] a, input logic [31:0] d);
    int r;
    r = cyc + 1;
    bus.host_req = 1'b1;
    bus.host_addr = a;
    bus.host_data = d;
    exp_ack = (r > host_avail) ? r : host_avail;
    push_stb(exp_ack, a, d, 1'b1);
  endtask

  task automatic host_wait();
    int n;
    n = 0;
    @(negedge clock);
    while (!bus.host_ack && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!bus.host_ack) chk("host_ack_timeout", 64'd0, 64'd1);
    bus.host_req = 1'b0;
    host_avail = exp_ack + GAP + 1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic fill_table(input int end_pos);
    for (int i = 0; i < N; i++) begin
      if (i == end_pos) rom[i] = {END, $urandom};
      else rom[i] = {8'($urandom_range(0, 254)), $urandom};
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_set_stb"}, 64'(bus.set_stb), 64'd0);
    chk({tag, "_set_addr"}, 64'(bus.set_addr), 64'd0);
    chk({tag, "_set_data"}, 64'(bus.set_data), 64'd0);
    chk({tag, "_host_ack"}, 64'(bus.host_ack), 64'd0);
    chk({tag, "_tbl_idx"}, 64'(tbl_idx), 64'd0);
    chk({tag, "_dot11_reset"}, 64'(dot11_reset), 64'd1);
    chk({tag, "_dot11_enable"}, 64'(dot11_enable), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // Monitor: compares strobes and done pulses against the predicted queues.
  initial begin
    stb_t        e;
    int          d;
    logic [7:0]  last_addr;
    logic [31:0] last_data;
    last_addr = 8'd0;
    last_data = 32'd0;
    forever begin
      @(posedge clock);
      #1;
      if (!rst_n) begin
        last_addr = 8'd0;
        last_data = 32'd0;
      end else begin
        if (bus.set_stb) begin
          if (exp_stb.size() == 0) begin
            chk("unexpected_stb", 64'd1, 64'd0);
          end else begin
            e = exp_stb.pop_front();
            chk("stb_cycle", 64'(cyc), 64'(e.cyc));
            chk("stb_addr", 64'(bus.set_addr), 64'(e.addr));
            chk("stb_data", 64'(bus.set_data), 64'(e.data));
            chk("stb_host_ack", 64'(bus.host_ack), 64'(e.host));
            if (!e.host) chk("stb_dot11_reset", 64'(dot11_reset), 64'd1);
          end
          last_addr = bus.set_addr;
          last_data = bus.set_data;
        end else begin
          chk("ack_without_stb", 64'(bus.host_ack), 64'd0);
          chk("hold_addr", 64'(bus.set_addr), 64'(last_addr));
          chk("hold_data", 64'(bus.set_data), 64'(last_data));
        end
        while (exp_stb.size() > 0 && exp_stb[0].cyc < cyc) begin
          e = exp_stb.pop_front();
          chk("missed_stb_cycle", 64'd0, 64'(e.cyc));
        end
        if (done) begin
          if (exp_done.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            d = exp_done.pop_front();
            chk("done_cycle", 64'(cyc), 64'(d));
          end
          chk("done_dot11_enable", 64'(dot11_enable), 64'd1);
          chk("done_dot11_reset", 64'(dot11_reset), 64'd0);
          chk("done_busy", 64'(busy), 64'd0);
        end
        while (exp_done.size() > 0 && exp_done[0] < cyc) begin
          d = exp_done.pop_front();
          chk("missed_done_cycle", 64'd0, 64'(d));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    int s;
    int done_c;
    int last_idx;
    rst_n = 1'b1;
    start = 1'b0;
    bus.host_req = 1'b0;
    bus.host_addr = 8'd0;
    bus.host_data = 32'd0;
    fill_table(N);
    #1 rst_n = 1'b0;
    #1 check_reset_values("por");
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);

    // Short table with an END entry; host request pending during bring-up
    // and a start pulse while busy that must be ignored.
    rom[0] = {SR_SKIP_SAMPLE, 32'h0};
    rom[1] = {8'h10, 32'hA5};
    rom[2] = {END, 32'h0};
    start = 1'b1;
    s = cyc + 1;
    model_bringup(s, done_c, last_idx);
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("dot11_reset_hold", 64'(dot11_reset), 64'd1);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    host_issue(8'h20, 32'hDEADBEEF);
    host_wait();
    chk("short_tbl_idx", 64'(tbl_idx), 64'(last_idx));
    chk("run_enable", 64'(dot11_enable), 64'd1);

    // Back-to-back host writes in S_RUN.
    host_issue(8'($urandom_range(0, 255)), $urandom);
    host_wait();
    host_issue(8'($urandom_range(0, 255)), $urandom);
    host_wait();
    repeat (4) @(negedge clock);

    // Restart coincident with a host request: start wins.
    fill_table(N);
    start = 1'b1;
    s = cyc + 1;
    model_bringup(s, done_c, last_idx);
    host_issue(8'h33, 32'h12345678);
    @(negedge clock);
    start = 1'b0;
    chk("restart_dot11_reset", 64'(dot11_reset), 64'd1);
    chk("restart_dot11_enable", 64'(dot11_enable), 64'd0);
    chk("restart_no_ack", 64'(bus.host_ack), 64'd0);
    host_wait();
    chk("full_tbl_idx", 64'(tbl_idx), 64'(N - 1));
    repeat (4) @(negedge clock);

    // Randomized restarts with random END positions and host traffic.
    for (int it = 0; it < 4; it++) begin
      fill_table(int'($urandom_range(0, N)));
      start = 1'b1;
      s = cyc + 1;
      model_bringup(s, done_c, last_idx);
      @(negedge clock);
      start = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        repeat (2) @(negedge clock);
        host_issue(8'($urandom_range(0, 255)), $urandom);
        host_wait();
      end else begin
        wait_until(done_c + 2);
      end
      chk("rand_tbl_idx", 64'(tbl_idx), 64'(last_idx));
      host_issue(8'($urandom_range(0, 255)), $urandom);
      host_wait();
      host_issue(8'($urandom_range(0, 255)), $urandom);
      host_wait();
      repeat (4) @(negedge clock);
    end

    // Asynchronous reset between two table strobes with a host request pending.
    fill_table(N);
    start = 1'b1;
    s = cyc + 1;
    model_bringup(s, done_c, last_idx);
    @(negedge clock);
    start = 1'b0;
    host_issue(8'h44, 32'hCAFEF00D);
    wait_until(s + RST + 3);
    @(posedge clock);
    #3 rst_n = 1'b0;
    #1 check_reset_values("async");
    exp_stb.delete();
    exp_done.delete();
    bus.host_req = 1'b0;
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    repeat (20) @(negedge clock);
    check_reset_values("post_reset");

    // Fresh bring-up after the abort.
    fill_table(N);
    start = 1'b1;
    s = cyc + 1;
    model_bringup(s, done_c, last_idx);
    @(negedge clock);
    start = 1'b0;
    wait_until(done_c + 3);
    chk("final_tbl_idx", 64'(tbl_idx), 64'(N - 1));
    chk("final_busy", 64'(busy), 64'd0);
    repeat (4) @(negedge clock);

    chk("leftover_stb", 64'(exp_stb.size()), 64'd0);
    chk("leftover_done", 64'(exp_done.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
